// File: rtl/dcache_mem_arbiter.sv
// Round-robin arbiter between dcache miss/writeback ports and one
// external memory read/write channel, one transaction at a time.
module dcache_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic                                    mem_read_valid,
    output logic [ADDR_BITS-1:0]                    mem_read_address,
    input  logic                                    mem_read_ready,
    input  logic [DATA_BITS-1:0]                    mem_read_data,
    output logic                                    mem_write_valid,
    output logic [ADDR_BITS-1:0]                    mem_write_address,
    output logic [DATA_BITS-1:0]                    mem_write_data,
    input  logic                                    mem_write_ready
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ_WAIT  = 2'd1;
    localparam logic [1:0] WRITE_WAIT = 2'd2;
    localparam logic [1:0] RELEASE    = 2'd3;

    logic [1:0]                              state_q, state_d;
    logic [IDX_BITS-1:0]                     rr_q, rr_d;
    logic [IDX_BITS-1:0]                     gnt_q, gnt_d;
    logic                                    rel_rd_q, rel_rd_d;
    logic                                    mem_rd_valid_q, mem_rd_valid_d;
    logic                                    mem_wr_valid_q, mem_wr_valid_d;
    logic [ADDR_BITS-1:0]                    rd_addr_q, rd_addr_d;
    logic [ADDR_BITS-1:0]                    wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]                    wr_data_q, wr_data_d;
    logic [NUM_CONSUMERS-1:0]                rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]                wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;

    logic                                    found;
    logic [IDX_BITS-1:0]                     pick;
    logic [IDX_BITS:0]                       scan_sum;
    logic [IDX_BITS-1:0]                     scan_idx;

    // Find the first requesting consumer at or after the round-robin pointer
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            scan_sum = {1'b0, rr_q} + (IDX_BITS+1)'(i);
            if (scan_sum >= (IDX_BITS+1)'(NUM_CONSUMERS)) begin
                scan_sum = scan_sum - (IDX_BITS+1)'(NUM_CONSUMERS);
            end
            scan_idx = scan_sum[IDX_BITS-1:0];
            if (!found && (consumer_read_valid[scan_idx] ||
                           consumer_write_valid[scan_idx])) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    // Transaction sequencing: grant, wait on memory, hand back, release
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        gnt_d          = gnt_q;
        rel_rd_d       = rel_rd_q;
        mem_rd_valid_d = mem_rd_valid_q;
        mem_wr_valid_d = mem_wr_valid_q;
        rd_addr_d      = rd_addr_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        rd_ready_d     = rd_ready_q;
        wr_ready_d     = wr_ready_q;
        rd_data_d      = rd_data_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d = pick;
                    if (consumer_read_valid[pick]) begin
                        rd_addr_d      = consumer_read_address[pick];
                        mem_rd_valid_d = 1'b1;
                        state_d        = READ_WAIT;
                    end else begin
                        wr_addr_d      = consumer_write_address[pick];
                        wr_data_d      = consumer_write_data[pick];
                        mem_wr_valid_d = 1'b1;
                        state_d        = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    rd_data_d[gnt_q]  = mem_read_data;
                    rd_ready_d[gnt_q] = 1'b1;
                    mem_rd_valid_d    = 1'b0;
                    rel_rd_d          = 1'b1;
                    state_d           = RELEASE;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    wr_ready_d[gnt_q] = 1'b1;
                    mem_wr_valid_d    = 1'b0;
                    rel_rd_d          = 1'b0;
                    state_d           = RELEASE;
                end
            end
            RELEASE: begin
                if (rel_rd_q ? !consumer_read_valid[gnt_q]
                             : !consumer_write_valid[gnt_q]) begin
                    rd_ready_d = '0;
                    wr_ready_d = '0;
                    if (gnt_q == IDX_BITS'(NUM_CONSUMERS-1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = gnt_q + IDX_BITS'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously so a reset abandons any transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            rr_q           <= '0;
            gnt_q          <= '0;
            rel_rd_q       <= 1'b0;
            mem_rd_valid_q <= 1'b0;
            mem_wr_valid_q <= 1'b0;
            rd_addr_q      <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rd_ready_q     <= '0;
            wr_ready_q     <= '0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            gnt_q          <= gnt_d;
            rel_rd_q       <= rel_rd_d;
            mem_rd_valid_q <= mem_rd_valid_d;
            mem_wr_valid_q <= mem_wr_valid_d;
            rd_addr_q      <= rd_addr_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            rd_ready_q     <= rd_ready_d;
            wr_ready_q     <= wr_ready_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign mem_read_valid       = mem_rd_valid_q;
    assign mem_read_address     = rd_addr_q;
    assign mem_write_valid      = mem_wr_valid_q;
    assign mem_write_address    = wr_addr_q;
    assign mem_write_data       = wr_data_q;
    assign consumer_read_ready  = rd_ready_q;
    assign consumer_read_data   = rd_data_q;
    assign consumer_write_ready = wr_ready_q;

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Directed bench for dcache_mem_arbiter: single read, round-robin order,
// read-before-write, pointer wrap, async reset and memory backpressure.
module tb_dcache_mem_arbiter;

    localparam int A = 8;
    localparam int D = 8;
    localparam int N = 8;

    logic                clk;
    logic                reset;
    logic [N-1:0]        consumer_read_valid;
    logic [N-1:0][A-1:0] consumer_read_address;
    logic [N-1:0]        consumer_read_ready;
    logic [N-1:0][D-1:0] consumer_read_data;
    logic [N-1:0]        consumer_write_valid;
    logic [N-1:0][A-1:0] consumer_write_address;
    logic [N-1:0][D-1:0] consumer_write_data;
    logic [N-1:0]        consumer_write_ready;
    logic                mem_read_valid;
    logic [A-1:0]        mem_read_address;
    logic                mem_read_ready;
    logic [D-1:0]        mem_read_data;
    logic                mem_write_valid;
    logic [A-1:0]        mem_write_address;
    logic [D-1:0]        mem_write_data;
    logic                mem_write_ready;

    int errors = 0;
    int checks = 0;

    dcache_mem_arbiter #(
        .ADDR_BITS(A),
        .DATA_BITS(D),
        .NUM_CONSUMERS(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .consumer_read_valid(consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready(consumer_read_ready),
        .consumer_read_data(consumer_read_data),
        .consumer_write_valid(consumer_write_valid),
        .consumer_write_address(consumer_write_address),
        .consumer_write_data(consumer_write_data),
        .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid),
        .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data),
        .mem_write_ready(mem_write_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = 1'b0;
        mem_read_data          = '0;
        mem_write_ready        = 1'b0;
        reset                  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Zero-wait memory read: waits for a request, answers it, then
    // withdraws the completed consumer's read valid.
    task automatic serve_read(input logic [7:0] rdata, output int idx,
                              output logic [7:0] addr);
        int n;
        n = 0;
        while (!mem_read_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rd_issue", mem_read_valid, 1);
        chk("rd_no_wr", mem_write_valid, 0);
        addr           = mem_read_address;
        mem_read_ready = 1'b1;
        mem_read_data  = rdata;
        @(negedge clk);
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        idx = -1;
        for (int i = 0; i < N; i++) begin
            if (consumer_read_ready[i]) idx = i;
        end
        chk("rd_onehot", $onehot(consumer_read_ready), 1);
        chk("rd_valid_drop", mem_read_valid, 0);
        if (idx >= 0) begin
            chk("rd_data", consumer_read_data[idx], rdata);
            consumer_read_valid[idx] = 1'b0;
        end
        @(negedge clk);
        chk("rd_release", consumer_read_ready, 0);
    endtask

    int          idx;
    logic [7:0]  addr;
    int          n;

    initial begin
        reset                  = 1'b0;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = 1'b0;
        mem_read_data          = '0;
        mem_write_ready        = 1'b0;

        // Reset state
        #12;
        chk("rst_mrv", mem_read_valid, 0);
        chk("rst_mwv", mem_write_valid, 0);
        chk("rst_maddr", {mem_read_address, mem_write_address}, 0);
        chk("rst_mwdata", mem_write_data, 0);
        chk("rst_crr", consumer_read_ready, 0);
        chk("rst_cwr", consumer_write_ready, 0);
        chk("rst_crd", consumer_read_data, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single read by consumer 2, memory answers two cycles later
        @(negedge clk);
        consumer_read_valid[2]   = 1'b1;
        consumer_read_address[2] = 8'h3A;
        @(negedge clk);
        chk("s_mrv", mem_read_valid, 1);
        chk("s_addr", mem_read_address, 8'h3A);
        chk("s_mwv", mem_write_valid, 0);
        @(negedge clk);
        chk("s_mrv_hold", mem_read_valid, 1);
        chk("s_rdy_wait", consumer_read_ready, 0);
        @(negedge clk);
        mem_read_ready = 1'b1;
        mem_read_data  = 8'h5C;
        @(negedge clk);
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        chk("s_rdy", consumer_read_ready, 8'h04);
        chk("s_data", consumer_read_data, 64'h0000_0000_005C_0000);
        chk("s_mrv_drop", mem_read_valid, 0);
        repeat (2) @(negedge clk);
        chk("s_rdy_hold", consumer_read_ready, 8'h04);
        consumer_read_valid[2] = 1'b0;
        @(negedge clk);
        chk("s_rdy_clr", consumer_read_ready, 0);
        chk("s_data_keep", consumer_read_data, 64'h0000_0000_005C_0000);

        // Round-robin: 0,3,7 from rr=0, then 0 and 7 again
        reset_dut();
        consumer_read_valid[0]   = 1'b1;
        consumer_read_address[0] = 8'h40;
        consumer_read_valid[3]   = 1'b1;
        consumer_read_address[3] = 8'h43;
        consumer_read_valid[7]   = 1'b1;
        consumer_read_address[7] = 8'h47;
        serve_read(8'h80, idx, addr);
        chk("rr1_idx", idx, 0);
        chk("rr1_addr", addr, 8'h40);
        serve_read(8'h83, idx, addr);
        chk("rr2_idx", idx, 3);
        chk("rr2_addr", addr, 8'h43);
        serve_read(8'h87, idx, addr);
        chk("rr3_idx", idx, 7);
        chk("rr3_addr", addr, 8'h47);
        consumer_read_valid[0]   = 1'b1;
        consumer_read_address[0] = 8'h50;
        consumer_read_valid[7]   = 1'b1;
        consumer_read_address[7] = 8'h57;
        serve_read(8'h90, idx, addr);
        chk("rr4_idx", idx, 0);
        chk("rr4_addr", addr, 8'h50);
        serve_read(8'h97, idx, addr);
        chk("rr5_idx", idx, 7);
        chk("rr5_addr", addr, 8'h57);
        chk("rr_data_all", consumer_read_data, 64'h9700_0000_8300_0090);

        // Read and write from consumer 1: read first, then write
        reset_dut();
        consumer_read_valid[1]    = 1'b1;
        consumer_read_address[1]  = 8'h10;
        consumer_write_valid[1]   = 1'b1;
        consumer_write_address[1] = 8'h11;
        consumer_write_data[1]    = 8'hAA;
        @(negedge clk);
        chk("rw_first_rd", {mem_read_valid, mem_write_valid}, 2'b10);
        serve_read(8'h3C, idx, addr);
        chk("rw_rd_idx", idx, 1);
        chk("rw_rd_addr", addr, 8'h10);
        n = 0;
        while (!mem_write_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rw_wr_issue", {mem_write_valid, mem_read_valid}, 2'b10);
        chk("rw_wr_addr", mem_write_address, 8'h11);
        chk("rw_wr_data", mem_write_data, 8'hAA);
        mem_write_ready = 1'b1;
        @(negedge clk);
        mem_write_ready = 1'b0;
        chk("rw_wr_rdy", consumer_write_ready, 8'h02);
        chk("rw_rd_rdy0", consumer_read_ready, 0);
        chk("rw_mwv_drop", mem_write_valid, 0);
        consumer_write_valid[1] = 1'b0;
        @(negedge clk);
        chk("rw_wr_clr", consumer_write_ready, 0);

        // Pointer wrap: serve 6, then 7 before 0
        reset_dut();
        consumer_read_valid[6]   = 1'b1;
        consumer_read_address[6] = 8'h66;
        serve_read(8'h16, idx, addr);
        chk("wrap6_idx", idx, 6);
        consumer_read_valid[0]   = 1'b1;
        consumer_read_address[0] = 8'h60;
        consumer_read_valid[7]   = 1'b1;
        consumer_read_address[7] = 8'h67;
        serve_read(8'h17, idx, addr);
        chk("wrap7_idx", idx, 7);
        chk("wrap7_addr", addr, 8'h67);
        serve_read(8'h10, idx, addr);
        chk("wrap0_idx", idx, 0);
        chk("wrap0_addr", addr, 8'h60);

        // Asynchronous reset while a read is outstanding
        reset_dut();
        consumer_read_valid[4]   = 1'b1;
        consumer_read_address[4] = 8'h44;
        @(negedge clk);
        chk("ar_mrv", mem_read_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_mrv0", mem_read_valid, 0);
        chk("ar_addr0", mem_read_address, 0);
        chk("ar_crr0", consumer_read_ready, 0);
        consumer_read_valid[4] = 1'b0;
        @(negedge clk);
        reset          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_late_rdy", consumer_read_ready, 0);
            chk("ar_late_data", consumer_read_data, 0);
            chk("ar_late_mrv", mem_read_valid, 0);
        end
        mem_read_ready = 1'b0;
        mem_read_data  = '0;

        // Backpressure: write stalls 20 cycles, no second request issued
        reset_dut();
        consumer_write_valid[5]   = 1'b1;
        consumer_write_address[5] = 8'h77;
        consumer_write_data[5]    = 8'h99;
        consumer_read_valid[6]    = 1'b1;
        consumer_read_address[6]  = 8'h22;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            chk("bp_hold", {mem_write_valid, mem_read_valid,
                            mem_write_address, mem_write_data},
                {2'b10, 8'h77, 8'h99});
            @(negedge clk);
        end
        mem_write_ready = 1'b1;
        @(negedge clk);
        mem_write_ready = 1'b0;
        chk("bp_wr_rdy", consumer_write_ready, 8'h20);
        consumer_write_valid[5] = 1'b0;
        @(negedge clk);
        chk("bp_wr_clr", consumer_write_ready, 0);
        serve_read(8'h61, idx, addr);
        chk("bp_rd_idx", idx, 6);
        chk("bp_rd_addr", addr, 8'h22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_mem_arbiter.md
DCACHE_MEM_ARBITER -- requirements
Module: dcache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 8, number of dcache miss/writeback ports (>=2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have ports consumer_read_valid  input  [NUM_CONSUMERS]  and consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  read requests from the dcache.
REQ-007 SHALL have ports consumer_read_ready  output  [NUM_CONSUMERS]  and consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  read completion.
REQ-008 SHALL have ports consumer_write_valid  input  [NUM_CONSUMERS], consumer_write_address  input  [NUM_CONSUMERS][ADDR_BITS], and consumer_write_data  input  [NUM_CONSUMERS][DATA_BITS]  write requests.
REQ-009 SHALL have port consumer_write_ready  output  [NUM_CONSUMERS]  write completion.
REQ-010 SHALL have ports mem_read_valid  output  1, mem_read_address  output  ADDR_BITS, mem_read_ready  input  1, mem_read_data  input  DATA_BITS  external memory read channel.
REQ-011 SHALL have ports mem_write_valid  output  1, mem_write_address  output  ADDR_BITS, mem_write_data  output  DATA_BITS, mem_write_ready  input  1  external memory write channel.

Function
REQ-012 SHALL implement FSM states IDLE, READ_WAIT, WRITE_WAIT, RELEASE; one transaction outstanding at a time.
REQ-013 SHALL in IDLE scan consumers from round-robin pointer rr upward (wrapping at NUM_CONSUMERS-1 -> 0) and grant the first with read or write valid.
REQ-014 SHALL, when the granted consumer has both read and write valid, serve the read first; the write is served on a later grant.
REQ-015 SHALL on grant register consumer index and address/data, assert mem_read_valid (READ_WAIT) or mem_write_valid (WRITE_WAIT) from the next cycle; memory outputs come from registers only.
REQ-016 SHALL hold mem_*_valid, address and data stable until mem_*_ready is sampled high; no timeout.
REQ-017 SHALL on mem_read_ready high: latch mem_read_data into consumer_read_data[g], drive consumer_read_ready[g]=1 next cycle, drop mem_read_valid, enter RELEASE.
REQ-018 SHALL on mem_write_ready high: drive consumer_write_ready[g]=1 next cycle, drop mem_write_valid, enter RELEASE.
REQ-019 SHALL hold consumer_*_ready[g] high in RELEASE until the matching consumer_*_valid[g] is sampled low, then clear ready, set rr=(g+1) mod NUM_CONSUMERS, return to IDLE.
REQ-020 SHALL keep consumer_read_data[g] stable from ready assertion until next read completion for g; other consumers' data unaffected.
REQ-021 SHALL ignore mem_*_ready when the corresponding mem_*_valid is low.
REQ-022 SHALL never assert mem_read_valid and mem_write_valid together, nor more than one consumer ready bit.
REQ-023 SHALL give minimum transaction latency of 3 cycles request-to-ready with zero-wait memory; IDLE grants no earlier than the cycle after RELEASE exits.
REQ-024 SHALL treat a consumer valid dropped before grant as withdrawn (no transaction).

Reset
REQ-025 SHALL on reset low, immediately and regardless of clk: state=IDLE, rr=0, all mem_*_valid=0, all consumer_*_ready=0, all registered address/data/consumer_read_data=0.
REQ-026 SHALL, on reset mid-transaction, abandon it with no completion reported after reset release.

Verification
REQ-027 Single read: consumer 2 reads 0x3A, memory ready 2 cycles later with 0x5C -> mem_read_address=0x3A, consumer_read_data[2]=0x5C, ready[2] high until valid[2] low.
REQ-028 Round-robin: consumers 0,3,7 read simultaneously, rr=0 -> served order 0,3,7; then 0 and 7 again with rr=0 -> 0 then 7.
REQ-029 Read+write same consumer: consumer 1 read 0x10 and write 0x11<-0xAA together -> read completes first, then mem_write_address=0x11, mem_write_data=0xAA.
REQ-030 Wrap: rr=7 after serving 6, consumers 0 and 7 request -> 7 served then 0.
REQ-031 Reset during READ_WAIT: reset low with mem_read_valid=1 -> all outputs 0 asynchronously; late mem_read_ready after release -> no consumer ready.
REQ-032 Backpressure: mem ready held low 20 cycles -> address/data/valid stable all 20 cycles; no second request issued.
